sz_code_packer: RTL and testbench
=================================

Name: sz_code_packer

Overview:
- Sits directly downstream of sz_inner on its 2-bit encode stream (data_out / data_out_valid).
- Packs 2-bit prediction codes MSB-first into 32-bit words, 16 codes per word, and buffers them in a small FIFO.
- Presents the words on a valid/ready port to the DMA/writer.
- On flush, emits a zero-padded partial word, then a trailer word carrying the exact code count, so the decoder can strip the padding.

Parameters:
- FIFO_DEPTH, 4: output word FIFO entries; power of two, minimum 2.
- CNT_W, 32: width of the code counter and of the trailer word; must be 32 or less.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- code_in  in  2  encode code from sz_inner data_out.
- code_valid  in  1  code_in is valid this cycle.
- code_ready  out  1  packer can accept a code this cycle.
- flush  in  1  end-of-stream pulse; sampled only in PACK.
- out_data  out  32  packed word (FIFO head).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_last  out  1  marks the trailer word, the last word of the stream.
- code_count  out  CNT_W  codes accepted in the current stream.
- busy  out  1  high in PAD or TRAIL, or while the FIFO is non-empty.

Behaviour:
- Reset (asynchronous, active-high): clears all outputs, the accumulator, fill (0..15), code_count and the FIFO, and puts the FSM in PACK.
- Reset asserted mid-stream discards all pending data; no partial word is emitted.
- Handshakes:
  - A code is accepted when code_valid && code_ready.
  - A word is popped when out_valid && out_ready.
  - out_data, out_valid and out_last stay stable until popped.
- code_ready = (state==PACK) && (fifo_count < FIFO_DEPTH). The check uses the registered count, so a simultaneous pop does not raise code_ready in that cycle.
- Packing:
  - The accepted code is written to acc bits [31-2*fill : 30-2*fill]; the first code of a word lands in [31:30].
  - fill increments and code_count increments, wrapping at 2^CNT_W.
  - When fill==15 and a code is accepted, the completed word is pushed into the FIFO with last=0, and fill/acc are cleared.
- Latency: the 16th code accepted at edge N gives out_valid=1 after edge N, if the FIFO was empty.
- FIFO:
  - Registered head; out_data reflects the FIFO head.
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - A push is never issued when full; code_ready already guarantees this.
- FSM states:
  - PACK: normal accept. flush=1 means go to PAD if fill>0, else go to TRAIL. A code accepted in the same cycle as flush is included first. If that code completes a word, the word is pushed and the next state is TRAIL.
  - PAD: code_ready=0. When FIFO not full, push acc (unused low bits zero) with last=0 and clear fill. Then go to TRAIL.
  - TRAIL: code_ready=0. When FIFO not full, push {code_count} zero-extended to 32 bits with last=1. Then clear code_count and go to PACK; a new stream may start the next cycle.
- Out of PACK: flush is ignored in PAD and TRAIL; code_valid is ignored unless code_ready is high.
- Empty stream: flush with code_count==0 emits only a trailer of 0x00000000 with out_last=1.

Decomposition:
- Package sz_pkg holds:
  - CODE_W=2, WORD_W=32, CODES_PER_WORD=16.
  - FSM state enum {PACK, PAD, TRAIL}.
  - Trailer format constant.
- One sub-module, sz_word_fifo: 33-bit wide (data + last), FIFO_DEPTH deep, with push/pop, full/empty and count.
- The packer instantiates sz_word_fifo once.

Test Plan:
- Full word: 16 codes 3,2,1,0 repeated, out_ready=1 → one word 0xE4E4E4E4, out_valid one cycle after the 16th code; code_count=16.
- Partial flush: 5 codes of 2'b01, then flush → 0x55400000 (last=0), then trailer 0x00000005 (last=1); code_count returns to 0; code_ready is high again in PACK.
- Backpressure:
  - out_ready=0 while streaming 16*FIFO_DEPTH codes of 2'b11 → FIFO fills with 0xFFFFFFFF; code_ready drops after the 64th code.
  - Raise out_ready → all 4 words drain in order and code_ready reasserts.
- Boundary flushes:
  - Flush on the same cycle as the 16th code → full word, then trailer 0x00000010; no pad word.
  - Flush with zero codes → only trailer 0x00000000 with last=1.
- Reset mid-stream: assert rst after 7 codes → out_valid=0, code_count=0 immediately (asynchronously). Then 16 codes of 0 → single word 0x00000000 with no stale bits.
- Random soak: random code_valid/out_ready/flush gaps → the decoded code stream equals the input; every trailer equals the number of codes in its stream.

Source files
------------

// File: rtl/sz_pkg.sv
`default_nettype none
// ============================================================================
//  sz_pkg : shared constants, FSM states and word format for sz_code_packer
//  Revision: 1.0
// ============================================================================
package sz_pkg;

    localparam int CODE_W         = 2;
    localparam int WORD_W         = 32;
    localparam int CODES_PER_WORD = 16;
    localparam int FILL_W         = 4;

    typedef enum logic [1:0] {
        PACK  = 2'd0,
        PAD   = 2'd1,
        TRAIL = 2'd2
    } state_t;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } word_t;

    localparam logic LAST_DATA    = 1'b0;
    localparam logic LAST_TRAILER = 1'b1;

    // Trailer: code count zero-extended to a full word, flagged as last.
    function automatic word_t trailer_word(input logic [WORD_W-1:0] count);
        return '{last: LAST_TRAILER, data: count};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sz_word_fifo.sv
`default_nettype none
// ============================================================================
//  sz_word_fifo : register-based FIFO, head read directly from storage
//  Revision: 1.0
// ============================================================================
module sz_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_DEPTH);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sz_code_packer.sv
`default_nettype none
// ============================================================================
//  sz_code_packer : packs 2-bit codes MSB-first into 32-bit words with a
//  pad word and code-count trailer at end of stream
//  Revision: 1.0
// ============================================================================
module sz_code_packer
    import sz_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        code_in,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic              flush,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_W-1:0]  code_count,
    output logic              busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]        DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(CODES_PER_WORD - 1);
    localparam logic [FILL_W-1:0]  FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [WORD_W-1:0]  acc;
    logic [WORD_W-1:0]  acc_ins;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_after;
    logic [4:0]         slot_lsb;
    logic               accept;
    logic               word_done;
    logic               room;
    logic               push;
    word_t              push_word;
    word_t              head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [AW:0]        fifo_count;

    assign room       = (fifo_count < DEPTH_CNT);
    assign accept     = code_valid && code_ready;
    assign word_done  = accept && (fill == FILL_LAST);
    assign fill_after = accept ? fill + FILL_ONE : fill;

    // First code of a word occupies bits [31:30], each later one 2 bits lower.
    assign slot_lsb = 5'(WORD_W - CODE_W) - {fill, 1'b0};
    assign acc_ins  = acc | (WORD_W'(code_in) << slot_lsb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PACK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PACK:    if (flush) state_nxt = (fill_after != '0) ? PAD : TRAIL;
            PAD:     if (!fifo_full) state_nxt = TRAIL;
            TRAIL:   if (!fifo_full) state_nxt = PACK;
            default: state_nxt = PACK;
        endcase
    end

    always_comb begin
        code_ready = 1'b0;
        push       = 1'b0;
        push_word  = '{last: LAST_DATA, data: acc_ins};
        case (state)
            PACK: begin
                code_ready = room;
                push       = code_valid && room && (fill == FILL_LAST);
            end
            PAD: begin
                push      = !fifo_full;
                push_word = '{last: LAST_DATA, data: acc};
            end
            TRAIL: begin
                push      = !fifo_full;
                push_word = trailer_word(WORD_W'(code_count));
            end
            default: begin
                code_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            fill       <= '0;
            code_count <= '0;
        end else begin
            if (accept) begin
                fill       <= fill_after;
                acc        <= word_done ? '0 : acc_ins;
                code_count <= code_count + CNT_ONE;
            end else if (state == PAD && !fifo_full) begin
                fill <= '0;
                acc  <= '0;
            end
            if (state == TRAIL && !fifo_full) begin
                code_count <= '0;
            end
        end
    end

    sz_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (out_valid && out_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_data  = head.data;
    assign out_last  = head.last && !fifo_empty;
    assign out_valid = !fifo_empty;
    assign busy      = (state != PACK) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_sz_code_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  tb_sz_code_packer : directed + random bench with a stream-level model
//  Revision: 1.0
// ============================================================================
module tb_sz_code_packer;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        code_in = 2'd0;
    logic              code_valid = 1'b0;
    logic              code_ready;
    logic              flush = 1'b0;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic [CNT_W-1:0]  code_count;
    logic              busy;

    sz_code_packer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .code_count (code_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];
    logic [32:0] seen[$];
    int          cur_codes[$];
    int          model_cnt = 0;
    bit          flushing = 1'b0;
    logic [32:0] exp_word;
    int          base;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic check_seen(input string name, input int idx, input logic [32:0] expv);
        if (idx < seen.size()) begin
            check(name, 64'(seen[idx]), 64'(expv));
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no word, expected 0x%0h", name, expv);
        end
    endtask

    // Codes of a word placed MSB-first, unused low slots zero.
    function automatic logic [31:0] pack_cur();
        logic [31:0] w;
        w = '0;
        foreach (cur_codes[i]) w = w | (32'(cur_codes[i]) << (30 - 2 * i));
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur_codes.delete();
            model_cnt = 0;
            flushing  = 1'b0;
        end else begin
            if (flushing) begin
                if (!busy) begin
                    check("count_after_trailer", 64'(code_count), 64'd0);
                    flushing = 1'b0;
                end
            end else begin
                check("code_count", 64'(code_count), 64'(model_cnt));
            end
            if (out_valid && out_ready) begin
                seen.push_back({out_last, out_data});
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", {out_last, out_data});
                end else begin
                    exp_word = exp_q.pop_front();
                    check("word", 64'({out_last, out_data}), 64'(exp_word));
                end
            end
            if (code_valid && code_ready) begin
                cur_codes.push_back(int'(code_in));
                model_cnt++;
                if (cur_codes.size() == 16) begin
                    exp_q.push_back({1'b0, pack_cur()});
                    cur_codes.delete();
                end
            end
            if (flush) begin
                if (cur_codes.size() > 0) exp_q.push_back({1'b0, pack_cur()});
                exp_q.push_back({1'b1, 32'(model_cnt)});
                cur_codes.delete();
                model_cnt = 0;
                flushing  = 1'b1;
            end
        end
    end

    task automatic send_code(input logic [1:0] c, input bit with_flush);
        int t;
        t = 0;
        code_in    = c;
        code_valid = 1'b1;
        flush      = with_flush;
        do begin
            @(negedge clk);
            t++;
        end while (!code_ready && t < 200);
        if (!code_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got code_ready=0, expected 1");
        end
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_code_count", 64'(code_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_code_ready", 64'(code_ready), 64'd1);

        // Full word 3,2,1,0 repeated
        base = seen.size();
        for (int i = 0; i < 16; i++) send_code(2'(3 - (i % 4)), 1'b0);
        check("full_valid_latency", 64'(out_valid), 64'd1);
        check("full_data", 64'(out_data), 64'hE4E4E4E4);
        check("full_count", 64'(code_count), 64'd16);
        do_flush();
        check_seen("full_word", base, {1'b0, 32'hE4E4E4E4});
        check_seen("full_trailer", base + 1, {1'b1, 32'h00000010});
        check("full_nwords", 64'(seen.size()), 64'(base + 2));

        // Partial word flush
        base = seen.size();
        for (int i = 0; i < 5; i++) send_code(2'b01, 1'b0);
        do_flush();
        check_seen("pad_word", base, {1'b0, 32'h55400000});
        check_seen("pad_trailer", base + 1, {1'b1, 32'h00000005});
        check("pad_nwords", 64'(seen.size()), 64'(base + 2));
        check("pad_count_cleared", 64'(code_count), 64'd0);
        check("pad_ready_again", 64'(code_ready), 64'd1);

        // Backpressure fills the FIFO
        base = seen.size();
        out_ready = 1'b0;
        for (int i = 0; i < 16 * FIFO_DEPTH; i++) send_code(2'b11, 1'b0);
        check("bp_ready_low", 64'(code_ready), 64'd0);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_head", 64'(out_data), 64'hFFFFFFFF);
        out_ready = 1'b1;
        wait_idle();
        check("bp_ready_back", 64'(code_ready), 64'd1);
        for (int i = 0; i < FIFO_DEPTH; i++) check_seen("bp_word", base + i, {1'b0, 32'hFFFFFFFF});
        do_flush();
        check_seen("bp_trailer", base + FIFO_DEPTH, {1'b1, 32'h00000040});

        // Flush together with the 16th code: no pad word
        base = seen.size();
        for (int i = 0; i < 15; i++) send_code(2'b10, 1'b0);
        send_code(2'b10, 1'b1);
        wait_idle();
        check_seen("edge_word", base, {1'b0, 32'hAAAAAAAA});
        check_seen("edge_trailer", base + 1, {1'b1, 32'h00000010});
        check("edge_nwords", 64'(seen.size()), 64'(base + 2));

        // Empty stream
        base = seen.size();
        do_flush();
        check_seen("empty_trailer", base, {1'b1, 32'h00000000});
        check("empty_nwords", 64'(seen.size()), 64'(base + 1));

        // Asynchronous reset mid-stream with a word pending
        out_ready = 1'b0;
        for (int i = 0; i < 23; i++) send_code(2'b01, 1'b0);
        check("prerst_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(code_count), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        base = seen.size();
        for (int i = 0; i < 16; i++) send_code(2'b00, 1'b0);
        do_flush();
        check_seen("post_rst_word", base, {1'b0, 32'h00000000});
        check_seen("post_rst_trailer", base + 1, {1'b1, 32'h00000010});
        check("post_rst_nwords", 64'(seen.size()), 64'(base + 2));

        // Random soak
        for (int cyc = 0; cyc < 1500; cyc++) begin
            code_valid = ($urandom_range(0, 3) != 0);
            code_in    = 2'($urandom_range(0, 3));
            out_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 60) == 0) begin
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush      = 1'b0;
                code_valid = 1'b0;
                out_ready  = 1'b1;
                wait_idle();
            end else begin
                @(posedge clk);
                #1;
            end
        end
        code_valid = 1'b0;
        out_ready  = 1'b1;
        do_flush();
        @(posedge clk);
        #1;
        check("model_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
